hazard_sequencer: RTL and testbench

//  Pipeline sequencer for the 9-bit CPU: detects load-use hazards, flushes on taken branches/jumps,

---
 rtl/cpu_pkg.sv | 34 +++
 rtl/forward_select.sv | 32 +++
 rtl/hazard_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_hazard_sequencer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared constants and types for the 9-bit CPU pipeline.
//                Holds the register index width, the special register
//                indices, the forwarding select encodings and the state
//                encodings of the hazard sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
package cpu_pkg;

    // Register index width and special-purpose indices. The special indices
    // are ordinary registers as far as hazard detection is concerned.
    localparam int REG_AW   = 4;
    localparam int ADR_REG  = 4;
    localparam int MATH_REG = 5;
    localparam int CNT_REG  = 7;

    // Operand forwarding select encodings
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    // Hazard sequencer states, explicitly encoded
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_STALL  = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_HALTED = 3'd4
    } seq_state_t;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/forward_select.sv
`default_nettype none
// ============================================================================
//  Module      : forward_select
//  Description : Combinational operand forwarding mux select for one ID-stage
//                source. The youngest producer (MEM) beats the older one (WB).
//  Revision    : 1.0  initial release
// ============================================================================
module forward_select #(
    parameter int REG_AW = 4
) (
    input  logic [REG_AW-1:0] src_reg,
    input  logic              src_used,
    input  logic              mem_write,
    input  logic [REG_AW-1:0] mem_write_reg,
    input  logic              wb_write,
    input  logic [REG_AW-1:0] wb_write_reg,
    output logic [1:0]        sel
);
    import cpu_pkg::*;

    // Pick the most recent in-flight producer of the source register
    always_comb begin
        sel = FWD_RF;
        if (src_used && mem_write && (mem_write_reg == src_reg)) begin
            sel = FWD_MEM;
        end else if (src_used && wb_write && (wb_write_reg == src_reg)) begin
            sel = FWD_WB;
        end
    end

endmodule : forward_select
`default_nettype wire

// File: rtl/hazard_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_sequencer
//  Description : Pipeline sequencer for the 9-bit CPU. Detects load-use
//                hazards, flushes on taken branches/jumps, drains and parks
//                the pipe on halt, and drives operand forwarding selects.
//                Optional macro HAZARD_PERF_EN adds saturating stall/flush
//                performance counters.
//  Revision    : 1.0  initial release
// ============================================================================
module hazard_sequencer #(
    parameter int REG_AW       = 4,
    parameter int DRAIN_CYCLES = 3
`ifdef HAZARD_PERF_EN
    ,
    parameter int PERF_W       = 16
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic [REG_AW-1:0] id_read_reg0,
    input  logic [REG_AW-1:0] id_read_reg1,
    input  logic              id_uses_r1,
    input  logic              id_halt,
    input  logic              ex_write,
    input  logic              ex_mem_to_reg,
    input  logic [REG_AW-1:0] ex_write_reg,
    input  logic              ex_branch,
    input  logic              ex_taken,
    input  logic              mem_write,
    input  logic [REG_AW-1:0] mem_write_reg,
    input  logic              wb_write,
    input  logic [REG_AW-1:0] wb_write_reg,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              running,
`ifdef HAZARD_PERF_EN
    output logic [PERF_W-1:0] stall_cycles,
    output logic [PERF_W-1:0] flush_count,
`endif
    output logic              halted
);
    import cpu_pkg::*;

    // A one-cycle drain still needs a 1-bit counter
    localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    seq_state_t       r_state;
    seq_state_t       w_next_state;
    logic [CNT_W-1:0] r_drain_cnt;
    logic             w_taken;
    logic             w_load_use;

    assign w_taken    = ex_branch & ex_taken;
    assign w_load_use = ex_write & ex_mem_to_reg &
                        ((ex_write_reg == id_read_reg0) |
                         (id_uses_r1 & (ex_write_reg == id_read_reg1)));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Drain countdown: loaded as halt enters EX, cleared by a squashing branch
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_drain_cnt <= '0;
        end else if ((r_state == ST_RUN) && (w_next_state == ST_DRAIN)) begin
            r_drain_cnt <= CNT_W'(DRAIN_CYCLES - 1);
        end else if (r_state == ST_DRAIN) begin
            if (w_taken || (r_drain_cnt == '0)) begin
                r_drain_cnt <= '0;
            end else begin
                r_drain_cnt <= r_drain_cnt - 1'b1;
            end
        end
    end

    // Next state and pipe enables/flushes; default is a held, flushed pipe
    always_comb begin
        w_next_state = r_state;
        pc_write     = 1'b0;
        ifid_write   = 1'b0;
        ifid_flush   = 1'b1;
        idex_flush   = 1'b1;
        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN, ST_STALL: begin
                if (w_taken) begin
                    // Squash the two younger slots and redirect the PC
                    pc_write     = 1'b1;
                    ifid_write   = 1'b1;
                    w_next_state = ST_RUN;
                end else if ((r_state == ST_RUN) && w_load_use) begin
                    // Hold PC and IF/ID, insert one bubble into EX
                    ifid_flush   = 1'b0;
                    w_next_state = ST_STALL;
                end else if ((r_state == ST_RUN) && id_halt) begin
                    // Let the halt itself move into EX, then stop fetching
                    ifid_flush   = 1'b0;
                    idex_flush   = 1'b0;
                    w_next_state = ST_DRAIN;
                end else begin
                    pc_write     = 1'b1;
                    ifid_write   = 1'b1;
                    ifid_flush   = 1'b0;
                    idex_flush   = 1'b0;
                    w_next_state = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (w_taken) begin
                    // The halt was on a mispredicted path: resume
                    pc_write     = 1'b1;
                    ifid_write   = 1'b1;
                    w_next_state = ST_RUN;
                end else if (r_drain_cnt == '0) begin
                    w_next_state = ST_HALTED;
                end
            end
            ST_HALTED: begin
                if (start_i) begin
                    w_next_state = ST_RUN;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    assign running = (r_state == ST_RUN) || (r_state == ST_STALL);
    assign halted  = (r_state == ST_HALTED);

    forward_select #(
        .REG_AW (REG_AW)
    ) u_fwd_a (
        .src_reg       (id_read_reg0),
        .src_used      (1'b1),
        .mem_write     (mem_write),
        .mem_write_reg (mem_write_reg),
        .wb_write      (wb_write),
        .wb_write_reg  (wb_write_reg),
        .sel           (fwd_a)
    );

    forward_select #(
        .REG_AW (REG_AW)
    ) u_fwd_b (
        .src_reg       (id_read_reg1),
        .src_used      (id_uses_r1),
        .mem_write     (mem_write),
        .mem_write_reg (mem_write_reg),
        .wb_write      (wb_write),
        .wb_write_reg  (wb_write_reg),
        .sel           (fwd_b)
    );

`ifdef HAZARD_PERF_EN
    logic w_perf_clear;
    logic w_flush_event;

    assign w_perf_clear  = start_i && ((r_state == ST_IDLE) || (r_state == ST_HALTED));
    assign w_flush_event = w_taken && ((r_state == ST_RUN) || (r_state == ST_STALL) ||
                                       (r_state == ST_DRAIN));

    // Saturating count of bubble cycles spent in STALL
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (w_perf_clear) begin
            stall_cycles <= '0;
        end else if ((r_state == ST_STALL) && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end

    // Saturating count of taken-branch flushes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flush_count <= '0;
        end else if (w_perf_clear) begin
            flush_count <= '0;
        end else if (w_flush_event && (flush_count != '1)) begin
            flush_count <= flush_count + 1'b1;
        end
    end
`endif

endmodule : hazard_sequencer
`default_nettype wire

// File: tb/tb_hazard_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_sequencer
//  Description : Self-checking bench for hazard_sequencer. Directed scenarios
//                followed by randomized stimulus, compared each cycle against
//                a flag-based behavioural model of the sequencing rules.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hazard_sequencer;

    localparam int AW    = 4;
    localparam int DRAIN = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          start_i;
    logic [AW-1:0] id_read_reg0, id_read_reg1;
    logic          id_uses_r1, id_halt;
    logic          ex_write, ex_mem_to_reg, ex_branch, ex_taken;
    logic [AW-1:0] ex_write_reg, mem_write_reg, wb_write_reg;
    logic          mem_write, wb_write;
    logic          pc_write, ifid_write, ifid_flush, idex_flush;
    logic [1:0]    fwd_a, fwd_b;
    logic          running, halted;
`ifdef HAZARD_PERF_EN
    logic [15:0]   stall_cycles, flush_count;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model: pipeline active, currently bubbling, drain slots
    // still to go, parked after halt. All clear means idle.
    bit m_on, m_bubble, m_parked;
    int m_drain_left;

    always #5 clk = ~clk;

    hazard_sequencer #(
        .REG_AW       (AW),
        .DRAIN_CYCLES (DRAIN)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start_i       (start_i),
        .id_read_reg0  (id_read_reg0),
        .id_read_reg1  (id_read_reg1),
        .id_uses_r1    (id_uses_r1),
        .id_halt       (id_halt),
        .ex_write      (ex_write),
        .ex_mem_to_reg (ex_mem_to_reg),
        .ex_write_reg  (ex_write_reg),
        .ex_branch     (ex_branch),
        .ex_taken      (ex_taken),
        .mem_write     (mem_write),
        .mem_write_reg (mem_write_reg),
        .wb_write      (wb_write),
        .wb_write_reg  (wb_write_reg),
        .pc_write      (pc_write),
        .ifid_write    (ifid_write),
        .ifid_flush    (ifid_flush),
        .idex_flush    (idex_flush),
        .fwd_a         (fwd_a),
        .fwd_b         (fwd_b),
        .running       (running),
`ifdef HAZARD_PERF_EN
        .stall_cycles  (stall_cycles),
        .flush_count   (flush_count),
`endif
        .halted        (halted)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        start_i = 0; id_read_reg0 = 0; id_read_reg1 = 0; id_uses_r1 = 0; id_halt = 0;
        ex_write = 0; ex_mem_to_reg = 0; ex_write_reg = 0; ex_branch = 0; ex_taken = 0;
        mem_write = 0; mem_write_reg = 0; wb_write = 0; wb_write_reg = 0;
    endtask

    task automatic model_reset();
        m_on = 0; m_bubble = 0; m_parked = 0; m_drain_left = 0;
    endtask

    function automatic bit is_taken();
        return ex_branch && ex_taken;
    endfunction

    function automatic bit is_load_use();
        return ex_write && ex_mem_to_reg &&
               (ex_write_reg == id_read_reg0 || (id_uses_r1 && ex_write_reg == id_read_reg1));
    endfunction

    // Compare all outputs against what the rules demand for the current inputs
    task automatic model_check();
        logic e_pc, e_ifw, e_iff, e_idf;
        bit   ck_ifw, ck_fl;
        logic [1:0] e_a, e_b;
        ck_ifw = 1; ck_fl = 1;
        e_pc = 0; e_ifw = 0; e_iff = 1; e_idf = 1;
        if (m_parked) begin
            ck_fl = 0;
        end else if (m_drain_left > 0) begin
            if (is_taken()) begin e_pc = 1; ck_ifw = 0; end
        end else if (m_on) begin
            if (is_taken()) begin
                e_pc = 1; ck_ifw = 0;
            end else if (!m_bubble && is_load_use()) begin
                e_iff = 0;
            end else if (!m_bubble && id_halt) begin
                e_iff = 0; e_idf = 0;
            end else begin
                e_pc = 1; e_ifw = 1; e_iff = 0; e_idf = 0;
            end
        end
        e_a = 2'b00;
        if (mem_write && mem_write_reg == id_read_reg0) e_a = 2'b01;
        else if (wb_write && wb_write_reg == id_read_reg0) e_a = 2'b10;
        e_b = 2'b00;
        if (id_uses_r1 && mem_write && mem_write_reg == id_read_reg1) e_b = 2'b01;
        else if (id_uses_r1 && wb_write && wb_write_reg == id_read_reg1) e_b = 2'b10;
        chk("pc_write", pc_write, e_pc);
        if (ck_ifw) chk("ifid_write", ifid_write, e_ifw);
        if (ck_fl) begin
            chk("ifid_flush", ifid_flush, e_iff);
            chk("idex_flush", idex_flush, e_idf);
        end
        chk("fwd_a", fwd_a, e_a);
        chk("fwd_b", fwd_b, e_b);
        chk("running", running, m_on);
        chk("halted", halted, m_parked);
    endtask

    // Advance the model by one clock using the inputs held across the edge
    task automatic model_update();
        if (!m_on && m_drain_left == 0) begin
            if (start_i) begin m_on = 1; m_bubble = 0; m_parked = 0; end
        end else if (m_drain_left > 0) begin
            if (is_taken()) begin
                m_drain_left = 0; m_on = 1; m_bubble = 0;
            end else begin
                m_drain_left--;
                if (m_drain_left == 0) m_parked = 1;
            end
        end else begin
            if (is_taken()) m_bubble = 0;
            else if (!m_bubble && is_load_use()) m_bubble = 1;
            else if (!m_bubble && id_halt) begin m_on = 0; m_drain_left = DRAIN; end
            else m_bubble = 0;
        end
    endtask

    // One clock: called just after a falling edge with inputs already set
    task automatic cycle();
        #1;
        model_check();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic randomize_inputs();
        start_i       = ($urandom_range(0, 7) == 0);
        id_read_reg0  = AW'($urandom_range(0, 3));
        id_read_reg1  = AW'($urandom_range(0, 3));
        id_uses_r1    = 1'($urandom_range(0, 1));
        id_halt       = ($urandom_range(0, 24) == 0);
        ex_write      = 1'($urandom_range(0, 1));
        ex_mem_to_reg = 1'($urandom_range(0, 1));
        ex_write_reg  = AW'($urandom_range(0, 3));
        ex_branch     = ($urandom_range(0, 4) == 0);
        ex_taken      = 1'($urandom_range(0, 1));
        mem_write     = 1'($urandom_range(0, 1));
        mem_write_reg = AW'($urandom_range(0, 3));
        wb_write      = 1'($urandom_range(0, 1));
        wb_write_reg  = AW'($urandom_range(0, 3));
    endtask

    initial begin
        clear_inputs();
        model_reset();
        reset = 1;
        repeat (2) @(negedge clk);
        // Reset values
        chk("rst_pc_write", pc_write, 0);
        chk("rst_ifid_write", ifid_write, 0);
        chk("rst_ifid_flush", ifid_flush, 1);
        chk("rst_idex_flush", idex_flush, 1);
        chk("rst_fwd_a", fwd_a, 0);
        chk("rst_running", running, 0);
        chk("rst_halted", halted, 0);
        reset = 0;

        // Idle holds until started; start moves to RUN next cycle
        cycle();
        start_i = 1; cycle(); start_i = 0;
        #1 chk("start_pc_write", pc_write, 1);
        chk("start_ifid_flush", ifid_flush, 0);

        // Load-use: r1 loaded in EX, ID reads r1
        ex_write = 1; ex_mem_to_reg = 1; ex_write_reg = 1; id_read_reg0 = 1;
        #1 chk("lu_pc_write", pc_write, 0);
        chk("lu_idex_flush", idex_flush, 1);
        cycle();
        clear_inputs();
        #1 chk("lu_bubble_pc", pc_write, 1);
        cycle();

        // Taken branch wins over a simultaneous load-use
        ex_write = 1; ex_mem_to_reg = 1; ex_write_reg = 2; id_read_reg0 = 2;
        ex_branch = 1; ex_taken = 1;
        #1 chk("tk_ifid_flush", ifid_flush, 1);
        chk("tk_idex_flush", idex_flush, 1);
        chk("tk_pc_write", pc_write, 1);
        cycle();
        clear_inputs();
        #1 chk("tk_no_stall", pc_write, 1);

        // Forwarding: MEM beats WB, then WB alone
        mem_write = 1; mem_write_reg = 5; wb_write = 1; wb_write_reg = 5; id_read_reg0 = 5;
        #1 chk("fwd_mem", fwd_a, 2'b01);
        mem_write = 0;
        #1 chk("fwd_wb", fwd_a, 2'b10);
        cycle();
        clear_inputs();

        // Halt: three drain cycles, halted on the fourth, restart
        id_halt = 1; cycle(); clear_inputs();
        for (int i = 0; i < DRAIN; i++) begin
            #1 chk("drain_not_halted", halted, 0);
            cycle();
        end
        #1 chk("halted_4th", halted, 1);
        start_i = 1; cycle(); start_i = 0;
        #1 chk("restart_running", running, 1);

        // Reset in the middle of a drain
        id_halt = 1; cycle(); clear_inputs(); cycle();
        reset = 1;
        #1 chk("mid_rst_halted", halted, 0);
        chk("mid_rst_running", running, 0);
        chk("mid_rst_ifid_flush", ifid_flush, 1);
        chk("mid_rst_idex_flush", idex_flush, 1);
`ifdef HAZARD_PERF_EN
        chk("mid_rst_stall_cnt", stall_cycles, 0);
        chk("mid_rst_flush_cnt", flush_count, 0);
`endif
        model_reset();
        @(negedge clk);
        reset = 0;

        // Randomized stimulus against the model
        for (int n = 0; n < 600; n++) begin
            randomize_inputs();
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_hazard_sequencer
`default_nettype wire
